// File: rtl/comparador_serie_ctrl.sv
// Bit-serial magnitude comparator controller: walks both operands MSB first
// through an external 1-bit cascade comparator and registers the final verdict.
module comparador_serie_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ocupado,
    output logic             listo,
    output logic             igual,
    output logic             mayor,
    output logic             menor,
    output logic             error,
    output logic             cmp_A,
    output logic             cmp_B,
    output logic             cmp_igual_i,
    output logic             cmp_mayor_i,
    output logic             cmp_menor_i,
    input  logic             cmp_igual_o,
    input  logic             cmp_mayor_o,
    input  logic             cmp_menor_o,
    output logic [1:0]       estado_dbg
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } estado_t;

    // Handshake: inicio is a request honoured only in REPOSO (ocupado=0);
    // listo is a single-cycle pulse in FIN, and results stay valid until the next FIN.
    estado_t          estado;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [IDX_W-1:0] idx;
    logic             f_igual;
    logic             f_mayor;
    logic             f_menor;

    logic [IDX_W-1:0] idx_dec;
    logic             ultimo;
    logic             one_hot;

    assign idx_dec    = idx - 1'b1;
    assign ultimo     = (idx == '0) || ((EARLY_EXIT != 0) && !cmp_igual_o);
    assign one_hot    = (cmp_igual_o ^ cmp_mayor_o ^ cmp_menor_o) &&
                        !(cmp_igual_o & cmp_mayor_o & cmp_menor_o);
    assign estado_dbg = estado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= REPOSO;
            reg_a       <= '0;
            reg_b       <= '0;
            idx         <= '0;
            f_igual     <= 1'b0;
            f_mayor     <= 1'b0;
            f_menor     <= 1'b0;
            ocupado     <= 1'b0;
            listo       <= 1'b0;
            igual       <= 1'b0;
            mayor       <= 1'b0;
            menor       <= 1'b0;
            error       <= 1'b0;
            cmp_A       <= 1'b0;
            cmp_B       <= 1'b0;
            cmp_igual_i <= 1'b0;
            cmp_mayor_i <= 1'b0;
            cmp_menor_i <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        reg_a       <= A;
                        reg_b       <= B;
                        f_igual     <= 1'b1;
                        f_mayor     <= 1'b0;
                        f_menor     <= 1'b0;
                        idx         <= IDX_W'(WIDTH - 1);
                        // Present the MSB straight away so the first COMPARA cycle is useful.
                        cmp_A       <= A[WIDTH-1];
                        cmp_B       <= B[WIDTH-1];
                        cmp_igual_i <= 1'b1;
                        cmp_mayor_i <= 1'b0;
                        cmp_menor_i <= 1'b0;
                        ocupado     <= 1'b1;
                        estado      <= COMPARA;
                    end
                end
                COMPARA: begin
                    f_igual <= cmp_igual_o;
                    f_mayor <= cmp_mayor_o;
                    f_menor <= cmp_menor_o;
                    if (ultimo) begin
                        igual       <= cmp_igual_o;
                        mayor       <= cmp_mayor_o;
                        menor       <= cmp_menor_o;
                        error       <= !one_hot;
                        listo       <= 1'b1;
                        cmp_A       <= 1'b0;
                        cmp_B       <= 1'b0;
                        cmp_igual_i <= 1'b0;
                        cmp_mayor_i <= 1'b0;
                        cmp_menor_i <= 1'b0;
                        estado      <= FIN;
                    end else begin
                        idx         <= idx_dec;
                        cmp_A       <= reg_a[idx_dec];
                        cmp_B       <= reg_b[idx_dec];
                        cmp_igual_i <= cmp_igual_o;
                        cmp_mayor_i <= cmp_mayor_o;
                        cmp_menor_i <= cmp_menor_o;
                    end
                end
                FIN: begin
                    listo   <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
                default: begin
                    listo   <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/comparador_serie_ctrl.md
COMPARADOR_SERIE_CTRL -- requirements
Module: comparador_serie_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter EARLY_EXIT, default 0; when set to 1, the block stops at the first unequal bit.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 inicio  in  1  start request; sampled only in REPOSO.
REQ-006 A, B  in  WIDTH each  operands; sampled only on the accepting edge.
REQ-007 ocupado  out  1  high while an operation is in progress.
REQ-008 listo  out  1  one-cycle completion pulse.
REQ-009 igual, mayor, menor  out  1 each  registered result (A==B, A>B, A<B).
REQ-010 error  out  1  registered; high when the comparator returned a non-one-hot flag set.
REQ-011 cmp_A, cmp_B  out  1 each  operand bits driven to the external 1-bit comparator.
REQ-012 cmp_igual_i, cmp_mayor_i, cmp_menor_i  out  1 each  cascade inputs driven to the comparator.
REQ-013 cmp_igual_o, cmp_mayor_o, cmp_menor_o  in  1 each  cascade outputs returned by the comparator.

Function
REQ-014 The FSM SHALL have exactly three states: REPOSO, COMPARA and FIN.
REQ-015 REPOSO, inicio=1: the block SHALL capture A and B into internal registers, set flags to igual=1/mayor=0/menor=0, set idx=WIDTH-1 and go to COMPARA.
REQ-016 REPOSO, inicio=0: the block SHALL remain in REPOSO.
REQ-017 COMPARA: cmp_A=regA[idx], cmp_B=regB[idx], and cmp_*_i SHALL equal the flag registers; all of these outputs SHALL come directly from registers, with no combinational path from any input.
REQ-018 Each COMPARA edge SHALL load the flags from cmp_*_o.
REQ-019 On that same edge, the block SHALL go to FIN if idx==0, or if EARLY_EXIT=1 and cmp_igual_o=0; otherwise it SHALL decrement idx (MSB first, no wrap past 0).
REQ-020 On the COMPARA->FIN edge, igual/mayor/menor SHALL load the final flags.
REQ-021 On the COMPARA->FIN edge, error SHALL load 1 unless exactly one of cmp_*_o is high.
REQ-022 FIN SHALL last exactly one cycle with listo=1, then return to REPOSO unconditionally.
REQ-023 ocupado SHALL be 1 in COMPARA and FIN and 0 in REPOSO.
REQ-024 inicio SHALL be ignored while ocupado=1, including an inicio coinciding with FIN.
REQ-025 Changes on A/B after the accepting edge SHALL have no effect on the result.
REQ-026 Latency with no early exit: listo SHALL be high in the cycle following edge WIDTH+1 after the accepting edge.
REQ-027 Latency with early exit at MSB-relative bit k (0 = MSB): listo SHALL be high in the cycle following edge k+2.
REQ-028 igual/mayor/menor/error SHALL hold their values until the next FIN entry and SHALL NOT clear on a new inicio.
REQ-029 In REPOSO and FIN, cmp_A, cmp_B and cmp_*_i SHALL be 0.
REQ-030 Back-to-back operation: inicio in the cycle after FIN SHALL be accepted, giving one idle cycle between operations.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, force state REPOSO.
REQ-032 rst=1 SHALL force ocupado=0, listo=0, igual=0, mayor=0, menor=0 and error=0.
REQ-033 rst=1 SHALL force all cmp_* outputs to 0, and the idx, flag and operand registers to 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no listo pulse; the first inicio after rst deasserts SHALL start a fresh operation.

Verification
REQ-035 The bench SHALL connect a behavioural Comparador1bit: if igual_i=1 it compares A,B; otherwise it passes mayor_i/menor_i through with igual_o=0.
REQ-036 WIDTH=8, EARLY_EXIT=0, A=8'h5A, B=8'h5A, inicio pulse -> ocupado high for 9 cycles; listo after edge 9; igual=1, mayor=0, menor=0, error=0.
REQ-037 WIDTH=8, A=8'h80, B=8'h7F -> mayor=1; listo after edge 9 with EARLY_EXIT=0, and after edge 2 with EARLY_EXIT=1.
REQ-038 WIDTH=8, EARLY_EXIT=0, A=8'h03, B=8'h04 -> menor=1, igual=0, mayor=0; cmp_A/cmp_B sequence 0/0,0/0,0/0,0/0,0/0,0/1,1/0,1/0.
REQ-039 rst pulsed during the 4th COMPARA cycle -> all outputs 0 at once, no listo; next operation A=8'hFF, B=8'h00 -> mayor=1.
REQ-040 inicio held high for 20 cycles with WIDTH=8, EARLY_EXIT=0 -> exactly two operations accepted, the 2nd one cycle after FIN.
REQ-041 A toggled every cycle mid-operation -> result reflects the captured value only.
REQ-042 The comparator model forced to return mayor_o=menor_o=1 on the last bit -> error=1, listo pulses normally, and error clears on the next clean operation.
